jk_universal_counter: RTL and testbench



---
 rtl/jk_pkg.sv | 13 +
 rtl/jk_cell.sv | 36 +++
 rtl/jk_universal_counter.sv | 105 ++++++++++
 tb/tb_jk_universal_counter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK-cell universal counter: mode encoding and its type.
package jk_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'b000;
  localparam mode_t MODE_JK    = 3'b001;
  localparam mode_t MODE_UP    = 3'b010;
  localparam mode_t MODE_DOWN  = 3'b011;
  localparam mode_t MODE_LOAD  = 3'b100;
  localparam mode_t MODE_CLEAR = 3'b101;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to a per-cell value.
module jk_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qn
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case ({J, K})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      default: q_d = ~q_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

endmodule

// File: rtl/jk_universal_counter.sv
// WIDTH-bit register of JK cells: hold, per-bit JK, modulo up/down count, load and clear.
module jk_universal_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MOD       = 2 ** WIDTH,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  mode_t            MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             TC,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] ModMax = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH is representable and range checks never fire.
  localparam logic [WIDTH:0]   ModW   = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] RstVec = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q, qn;
  logic [WIDTH-1:0] n_d;
  logic [WIDTH-1:0] cell_j, cell_k;
  logic             q_ge_mod, d_ge_mod;
  logic             ovf_q, ovf_d;

  assign q_ge_mod = {1'b0, q} >= ModW;
  assign d_ge_mod = {1'b0, D} >= ModW;

  always_comb begin
    n_d   = q;
    ovf_d = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_UP: begin
          if (q == ModMax || q_ge_mod) begin
            n_d   = '0;
            ovf_d = 1'b1;
          end else begin
            n_d = q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q == '0 || q_ge_mod) begin
            n_d   = ModMax;
            ovf_d = 1'b1;
          end else begin
            n_d = q - 1'b1;
          end
        end
        MODE_LOAD:  n_d = d_ge_mod ? ModMax : D;
        MODE_CLEAR: n_d = '0;
        default:    n_d = q;
      endcase
    end
  end

  // Non-JK modes steer each cell to set, clear or hold so it lands on n_d.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    if (EN) begin
      if (MODE == MODE_JK) begin
        cell_j = J;
        cell_k = K;
      end else begin
        cell_j = n_d & ~q;
        cell_k = ~n_d & q;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL(RstVec[i])
    ) u_cell (
      .CLK  (CLK),
      .RST_n(RST_n),
      .J    (cell_j[i]),
      .K    (cell_k[i]),
      .Q    (q[i]),
      .Qn   (qn[i])
    );
  end

  always_ff @(posedge CLK or posedge RST_n) begin
    if (RST_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign TC  = EN & (((MODE == MODE_UP) & (q == ModMax)) | ((MODE == MODE_DOWN) & (q == '0)));
  assign Q   = q;
  assign Qn  = qn;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_jk_universal_counter.sv
// Table-driven self-checking bench for jk_universal_counter (WIDTH=4, MOD=10).
module tb_jk_universal_counter;
  import jk_pkg::*;

  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         RST_n;
  logic         EN;
  mode_t        MODE;
  logic [W-1:0] J, K, D, Q, Qn;
  logic         TC, OVF;

  jk_universal_counter #(
    .WIDTH    (W),
    .MOD      (10),
    .RESET_VAL(0)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .EN   (EN),
    .MODE (MODE),
    .J    (J),
    .K    (K),
    .D    (D),
    .Q    (Q),
    .Qn   (Qn),
    .TC   (TC),
    .OVF  (OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         en;
    mode_t        mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] d;
    logic [W-1:0] q;    // Q after the edge
    logic         ovf;  // OVF after the edge
    logic         tc;   // TC before the edge
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input mode_t mode, input logic [W-1:0] j,
                              input logic [W-1:0] k, input logic [W-1:0] d,
                              input logic [W-1:0] q, input logic ovf, input logic tc);
    vec_t v;
    v.en = en; v.mode = mode; v.j = j; v.k = k; v.d = d;
    v.q = q; v.ovf = ovf; v.tc = tc;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t         e;
    logic [W-1:0] nq;
    @(negedge CLK);
    EN = v.en; MODE = v.mode; J = v.j; K = v.k; D = v.d;
    #1;
    check({tag, " TC"}, 32'(TC), 32'(v.tc));
    sb.push_back('{q: v.q, ovf: v.ovf});
    @(posedge CLK);
    #1;
    e  = sb.pop_front();
    nq = ~e.q;
    check({tag, " Q"}, 32'(Q), 32'(e.q));
    check({tag, " Qn"}, 32'(Qn), 32'(nq));
    check({tag, " OVF"}, 32'(OVF), 32'(e.ovf));
  endtask

  initial begin
    RST_n = 1'b1; EN = 1'b1; MODE = MODE_UP; J = '0; K = '0; D = '0;

    // Edges under reset must not move the register.
    repeat (2) @(posedge CLK);
    #1;
    check("reset Q", 32'(Q), 32'h0);
    check("reset Qn", 32'(Qn), 32'hF);
    check("reset OVF", 32'(OVF), 32'h0);
    @(negedge CLK);
    EN = 1'b0; RST_n = 1'b0;

    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(1, MODE_UP, 0, 0, 0, 4'((i + 1) % 10), i == 9, i == 9));
    end
    vecs.push_back(mk(1, MODE_DOWN,  0, 0, 0, 4'd9, 1, 1));
    vecs.push_back(mk(1, MODE_DOWN,  0, 0, 0, 4'd8, 0, 0));
    vecs.push_back(mk(1, MODE_LOAD,  0, 0, 3, 4'd3, 0, 0));
    vecs.push_back(mk(1, MODE_JK, 4'b1010, 4'b0110, 0, 4'b1001, 0, 0));
    vecs.push_back(mk(0, MODE_UP,    0, 0, 0, 4'd9, 0, 0));
    vecs.push_back(mk(1, MODE_LOAD,  0, 0, 12, 4'd9, 0, 0));
    vecs.push_back(mk(1, MODE_LOAD,  0, 0, 5, 4'd5, 0, 0));
    vecs.push_back(mk(0, MODE_LOAD,  0, 0, 7, 4'd5, 0, 0));
    vecs.push_back(mk(1, MODE_JK, 4'b1101, 4'b0010, 0, 4'd13, 0, 0));
    vecs.push_back(mk(1, MODE_UP,    0, 0, 0, 4'd0, 1, 0));
    vecs.push_back(mk(1, 3'b111,     0, 0, 0, 4'd0, 0, 0));
    vecs.push_back(mk(1, MODE_JK, 4'b1101, 4'b0000, 0, 4'd13, 0, 0));
    vecs.push_back(mk(1, MODE_DOWN,  0, 0, 0, 4'd9, 1, 0));
    vecs.push_back(mk(1, 3'b110,     0, 0, 0, 4'd9, 0, 0));
    vecs.push_back(mk(1, MODE_CLEAR, 0, 0, 0, 4'd0, 0, 0));
    vecs.push_back(mk(1, MODE_JK, 4'b1111, 4'b1111, 0, 4'd15, 0, 0));
    vecs.push_back(mk(1, MODE_LOAD,  0, 0, 15, 4'd9, 0, 0));
    vecs.push_back(mk(1, MODE_HOLD,  0, 0, 0, 4'd9, 0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while counting at 7.
    apply(mk(1, MODE_LOAD, 0, 0, 6, 4'd6, 0, 0), "pre-rst load");
    apply(mk(1, MODE_UP, 0, 0, 0, 4'd7, 0, 0), "pre-rst up");
    #2;
    RST_n = 1'b1; EN = 1'b0;
    #1;
    check("midrst Q", 32'(Q), 32'h0);
    check("midrst OVF", 32'(OVF), 32'h0);
    @(negedge CLK);
    RST_n = 1'b0;
    apply(mk(1, MODE_UP, 0, 0, 0, 4'd1, 0, 0), "post-rst up");

    // Reset right after a wrap must drop the pending OVF pulse.
    apply(mk(1, MODE_LOAD, 0, 0, 9, 4'd9, 0, 0), "wrap load");
    apply(mk(1, MODE_UP, 0, 0, 0, 4'd0, 1, 1), "wrap up");
    #2;
    RST_n = 1'b1; EN = 1'b0;
    #1;
    check("ovf drop OVF", 32'(OVF), 32'h0);
    check("ovf drop Q", 32'(Q), 32'h0);
    @(negedge CLK);
    RST_n = 1'b0;
    apply(mk(1, MODE_UP, 0, 0, 0, 4'd1, 0, 0), "resume up");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
